// File: rtl/pixel_packer.sv
// ---------------------------------------------------------------------------
// pixel_packer
//   Packs a stream of 24-bit RGB pixels into 32-bit AXI-Stream words.
//   Four pixels {P3,P2,P1,P0} (96 bits) become three words sent low word
//   first. The first pixel of a group only loads the residue register. Each
//   of the next three pixels completes one word, so there is one word per
//   pixel after the first.
//
// Parameters
//   X_SIZE  pixels per line (multiple of 4, so groups never straddle lines)
//   Y_SIZE  lines per frame
//
// Ports
//   aclk             clock, rising edge
//   areset           synchronous active-high reset
//   in_r/in_g/in_b   upstream pixel colour, P = {in_r,in_g,in_b}
//   in_valid         upstream pixel valid
//   in_stream_ready  pixel accepted this cycle if in_valid is also high
//   out_tdata        AXI-Stream data word
//   out_tvalid       AXI-Stream valid
//   out_tready       AXI-Stream ready from the sink
//   out_tlast        last word of a line
//   out_tuser        first word of a frame
// ---------------------------------------------------------------------------
module pixel_packer #(
  parameter int X_SIZE = 640,
  parameter int Y_SIZE = 480
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [7:0]  in_r,
  input  logic [7:0]  in_g,
  input  logic [7:0]  in_b,
  input  logic        in_valid,
  output logic        in_stream_ready,
  output logic [31:0] out_tdata,
  output logic        out_tvalid,
  input  logic        out_tready,
  output logic        out_tlast,
  output logic        out_tuser
);

  localparam int XW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
  localparam int YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);

  // State
  logic [1:0]    phase_q, phase_d;
  logic [XW-1:0] x_q,     x_d;
  logic [YW-1:0] y_q,     y_d;
  logic [23:0]   res_q,   res_d;
  logic [31:0]   tdata_q, tdata_d;
  logic          tlast_q, tlast_d;
  logic          tuser_q, tuser_d;
  logic          tvalid_q, tvalid_d;

  // Per-cycle decode
  logic [23:0] pix;
  logic        accept;
  logic        emit;
  logic [31:0] word;

  assign pix = {in_r, in_g, in_b};

  // Free output slot whenever nothing is held or the held word leaves now.
  // Ready does not depend on in_valid.
  assign in_stream_ready = !tvalid_q || out_tready;
  assign accept          = in_valid && in_stream_ready;

  // Word assembly: each pixel after the first of a group finishes one word
  // using the bytes left over in the residue register.
  always_comb begin
    emit  = 1'b0;
    word  = '0;
    res_d = res_q;
    if (accept) begin
      unique case (phase_q)
        2'd0: begin
          res_d = pix;
        end
        2'd1: begin
          emit  = 1'b1;
          word  = {pix[7:0], res_q};
          res_d = {8'd0, pix[23:8]};
        end
        2'd2: begin
          emit  = 1'b1;
          word  = {pix[15:0], res_q[15:0]};
          res_d = {16'd0, pix[23:16]};
        end
        default: begin
          emit  = 1'b1;
          word  = {pix, res_q[7:0]};
          res_d = '0;
        end
      endcase
    end
  end

  // Position counters. Phase tracks x mod 4; it is kept as its own
  // register so the word mux does not depend on the x counter width.
  always_comb begin
    phase_d = phase_q;
    x_d     = x_q;
    y_d     = y_q;
    if (accept) begin
      phase_d = phase_q + 2'd1;
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  // Output register. A new word overrides the clear caused by a handshake,
  // so back-to-back words flow without a bubble. When the sink stalls,
  // accept is low, so nothing here changes.
  always_comb begin
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    tuser_d  = tuser_q;
    tvalid_d = tvalid_q;
    if (tvalid_q && out_tready) tvalid_d = 1'b0;
    if (emit) begin
      tvalid_d = 1'b1;
      tdata_d  = word;
      tlast_d  = (x_q == X_LAST);
      tuser_d  = (x_q == XW'(1)) && (y_q == '0);
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      phase_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      res_q    <= '0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
      tvalid_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      x_q      <= x_d;
      y_q      <= y_d;
      res_q    <= res_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      tuser_q  <= tuser_d;
      tvalid_q <= tvalid_d;
    end
  end

  assign out_tdata  = tdata_q;
  assign out_tvalid = tvalid_q;
  assign out_tlast  = tlast_q;
  assign out_tuser  = tuser_q;

endmodule

// File: tb/tb_pixel_packer.sv
// ---------------------------------------------------------------------------
// tb_pixel_packer
//   Random and directed stimulus for pixel_packer (X_SIZE=8, Y_SIZE=2).
//   A reference model rebuilds each 96-bit group from the pixels it accepts
//   and slices out words by index. A negedge process compares the DUT with
//   that model every cycle. Directed scenarios also check literal words and
//   marker positions taken from the handshake log.
// ---------------------------------------------------------------------------
module tb_pixel_packer;

  localparam int X = 8;
  localparam int Y = 2;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [7:0]  in_r = '0, in_g = '0, in_b = '0;
  logic        in_valid = 1'b0;
  logic        in_stream_ready;
  logic [31:0] out_tdata;
  logic        out_tvalid;
  logic        out_tready = 1'b1;
  logic        out_tlast;
  logic        out_tuser;

  pixel_packer #(.X_SIZE(X), .Y_SIZE(Y)) dut (
    .aclk(aclk), .areset(areset),
    .in_r(in_r), .in_g(in_g), .in_b(in_b), .in_valid(in_valid),
    .in_stream_ready(in_stream_ready),
    .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready),
    .out_tlast(out_tlast), .out_tuser(out_tuser)
  );

  always #5 aclk = ~aclk;

  int compared = 0;
  int mismatched = 0;

  typedef logic [33:0] ent_t;   // {last, user, data}
  ent_t dut_log[$];
  ent_t mdl_log[$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic        m_valid = 1'b0;
  logic [31:0] m_data  = '0;
  logic        m_last  = 1'b0;
  logic        m_user  = 1'b0;
  int          m_n     = 0;      // pixel index within the frame
  logic [95:0] m_grp   = '0;

  task automatic model_step();
    logic ready;
    int   x, y, k;
    if (areset) begin
      m_valid = 1'b0; m_data = '0; m_last = 1'b0; m_user = 1'b0;
      m_n = 0; m_grp = '0;
      return;
    end
    ready = !m_valid || out_tready;
    if (m_valid && out_tready) begin
      mdl_log.push_back({m_last, m_user, m_data});
      m_valid = 1'b0;
    end
    if (in_valid && ready) begin
      x = m_n % X;
      y = m_n / X;
      k = x % 4;
      m_grp[24*k +: 24] = {in_r, in_g, in_b};
      if (k > 0) begin
        m_valid = 1'b1;
        m_data  = m_grp[32*(k-1) +: 32];
        m_last  = (x == X-1);
        m_user  = (x == 1) && (y == 0);
      end
      m_n = (m_n + 1) % (X*Y);
    end
  endtask

  initial forever begin
    @(posedge aclk);
    model_step();
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge aclk);
    check1("ready", in_stream_ready, !m_valid || out_tready);
    check1("tvalid", out_tvalid, m_valid);
    if (m_valid) begin
      check32("tdata", out_tdata, m_data);
      check1("tlast", out_tlast, m_last);
      check1("tuser", out_tuser, m_user);
    end
    if (out_tvalid && out_tready && !areset)
      dut_log.push_back({out_tlast, out_tuser, out_tdata});
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", compared);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge aclk); #1;
  endtask

  task automatic set_pix(input logic [23:0] p);
    {in_r, in_g, in_b} = p;
  endtask

  task automatic do_reset(input int n);
    areset = 1'b1;
    in_valid = 1'b1;          // must be ignored while in reset
    set_pix(24'hBAD0BA);
    repeat (n) cyc();
    areset = 1'b0;
    in_valid = 1'b0;
    dut_log.delete();
    mdl_log.delete();
  endtask

  task automatic send(input logic [23:0] p);
    int t;
    set_pix(p);
    in_valid = 1'b1;
    t = 0;
    @(negedge aclk);
    while (!in_stream_ready && t < 50) begin
      @(negedge aclk);
      t++;
    end
    if (t >= 50) check1("send_timeout", 1'b0, 1'b1);
    @(posedge aclk); #1;
    in_valid = 1'b0;
  endtask

  task automatic check_word(input string name, input ent_t e,
                            input logic [31:0] d, input logic l, input logic u);
    check32({name, "_data"}, e[31:0], d);
    check1({name, "_last"}, e[33], l);
    check1({name, "_user"}, e[32], u);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    // Reset: sink not ready, so ready=1 must come from the empty output.
    out_tready = 1'b0;
    do_reset(2);
    check1("rst_tvalid", out_tvalid, 1'b0);
    check32("rst_tdata", out_tdata, 32'h0);
    check1("rst_tlast", out_tlast, 1'b0);
    check1("rst_tuser", out_tuser, 1'b0);
    check1("rst_ready", in_stream_ready, 1'b1);

    // Packing, with one-cycle visibility after each completing pixel.
    out_tready = 1'b1;
    send(24'h112233);
    check1("pk_p0_novalid", out_tvalid, 1'b0);
    send(24'h445566);
    check32("pk_w0_now", out_tdata, 32'h66112233);
    check1("pk_w0_user", out_tuser, 1'b1);
    send(24'h778899);
    check32("pk_w1_now", out_tdata, 32'h88994455);
    send(24'hAABBCC);
    check32("pk_w2_now", out_tdata, 32'hAABBCC77);
    repeat (3) cyc();
    check32("pk_count", 32'(dut_log.size()), 32'd3);
    check32("pk_mcount", 32'(mdl_log.size()), 32'd3);
    if (mdl_log.size() == 3) begin
      check_word("pk_m0", mdl_log[0], 32'h66112233, 1'b0, 1'b1);
      check_word("pk_m1", mdl_log[1], 32'h88994455, 1'b0, 1'b0);
      check_word("pk_m2", mdl_log[2], 32'hAABBCC77, 1'b0, 1'b0);
    end
    if (dut_log.size() == 3) begin
      check_word("pk_d0", dut_log[0], 32'h66112233, 1'b0, 1'b1);
      check_word("pk_d1", dut_log[1], 32'h88994455, 1'b0, 1'b0);
      check_word("pk_d2", dut_log[2], 32'hAABBCC77, 1'b0, 1'b0);
    end

    // Back-pressure: stall three cycles with word 0 pending.
    do_reset(1);
    out_tready = 1'b1;
    send(24'h112233);
    send(24'h445566);
    out_tready = 1'b0;
    set_pix(24'h778899);
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge aclk);
      check32("bp_hold_data", out_tdata, 32'h66112233);
      check1("bp_hold_valid", out_tvalid, 1'b1);
      check1("bp_ready_low", in_stream_ready, 1'b0);
      @(posedge aclk); #1;
    end
    out_tready = 1'b1;
    send(24'h778899);
    send(24'hAABBCC);
    repeat (3) cyc();
    check32("bp_count", 32'(dut_log.size()), 32'd3);
    if (dut_log.size() == 3) begin
      check32("bp_w0", dut_log[0][31:0], 32'h66112233);
      check32("bp_w1", dut_log[1][31:0], 32'h88994455);
      check32("bp_w2", dut_log[2][31:0], 32'hAABBCC77);
    end

    // Markers: 18 pixels -> 13 words spanning one full frame.
    do_reset(1);
    out_tready = 1'b1;
    for (int i = 0; i < 18; i++) send(24'($urandom));
    repeat (3) cyc();
    check32("mk_count", 32'(dut_log.size()), 32'd13);
    if (dut_log.size() == 13) begin
      for (int i = 0; i < 13; i++) begin
        check1($sformatf("mk_user%0d", i), dut_log[i][32], (i == 0) || (i == 12));
        check1($sformatf("mk_last%0d", i), dut_log[i][33], (i == 5) || (i == 11));
      end
    end

    // Mid-group reset: the partial group and the pending word are dropped.
    do_reset(1);
    out_tready = 1'b1;
    send(24'hDEAD01);
    send(24'hDEAD02);
    do_reset(1);
    out_tready = 1'b1;
    send(24'h010203);
    send(24'h040506);
    send(24'h070809);
    send(24'h0A0B0C);
    repeat (3) cyc();
    check32("mr_count", 32'(dut_log.size()), 32'd3);
    if (dut_log.size() == 3) begin
      check_word("mr_w0", dut_log[0], 32'h06010203, 1'b0, 1'b1);
      check32("mr_w1", dut_log[1][31:0], 32'h08090405);
      check32("mr_w2", dut_log[2][31:0], 32'h0A0B0C07);
    end

    // Throughput: 20 back-to-back pixels, ready never drops, 15 words.
    do_reset(1);
    out_tready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_pix(24'($urandom));
      @(negedge aclk);
      check1("tp_ready", in_stream_ready, 1'b1);
      @(posedge aclk); #1;
    end
    in_valid = 1'b0;
    repeat (3) cyc();
    check32("tp_count", 32'(dut_log.size()), 32'd15);

    // Random traffic with random stalls and occasional resets.
    do_reset(1);
    for (int i = 0; i < 3000; i++) begin
      areset     = ($urandom_range(0, 299) == 0);
      in_valid   = ($urandom_range(0, 3) != 0);
      out_tready = ($urandom_range(0, 2) != 0);
      set_pix(24'($urandom));
      cyc();
    end
    areset = 1'b0;
    in_valid = 1'b0;
    out_tready = 1'b1;
    repeat (4) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
